bcd_multi_counter: RTL and testbench

BCD_MULTI_COUNTER -- requirements
Module: bcd_multi_counter

---
 rtl/bcdcnt_pkg.sv | 20 ++
 rtl/bcd_digit.sv | 49 ++++
 rtl/bcd_multi_counter.sv | 122 ++++++++++++
 tb/tb_bcd_multi_counter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcdcnt_pkg.sv
// -----------------------------------------------------------------------------
// bcdcnt_pkg
// Shared constants, types and helpers for the cascaded BCD counter.
//   DIGIT_W     : width of one BCD digit
//   DIGIT_MAX   : largest legal BCD digit value
//   digit_t     : one BCD digit
//   clamp_digit : limits an arbitrary 4-bit value to the legal BCD range
// -----------------------------------------------------------------------------
package bcdcnt_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;

    typedef logic [DIGIT_W-1:0] digit_t;

    function automatic digit_t clamp_digit(input digit_t value);
        return (value > DIGIT_MAX) ? DIGIT_MAX : value;
    endfunction

endpackage : bcdcnt_pkg

// File: rtl/bcd_digit.sv
// -----------------------------------------------------------------------------
// bcd_digit
// Purely combinational next-value and carry/borrow logic for one BCD digit.
// Ports:
//   up         : direction, 1 = increment, 0 = decrement
//   advance    : this digit steps this cycle (all lower digits are at their
//                terminal value, or this is digit 0 of an enabled count)
//   value      : current digit value (may be out of range, >9)
//   next_value : digit value after the step (equals value when not advancing)
//   propagate  : this digit rolled over, so the next digit up must step too
// -----------------------------------------------------------------------------
module bcd_digit
    import bcdcnt_pkg::*;
(
    input  logic   up,
    input  logic   advance,
    input  digit_t value,
    output digit_t next_value,
    output logic   propagate
);

    // NOTE: every output of a combinational block gets a default first so
    // that no path through the ifs leaves it unassigned (which would infer a
    // latch).
    always_comb begin
        next_value = value;
        propagate  = 1'b0;
        if (advance) begin
            if (up) begin
                // Out-of-range digits (>9) count up to 0 with a carry, like 9.
                if (value >= DIGIT_MAX) begin
                    next_value = '0;
                    propagate  = 1'b1;
                end else begin
                    next_value = value + 4'd1;
                end
            end else begin
                // Only a true 0 borrows; out-of-range digits just step down.
                if (value == '0) begin
                    next_value = DIGIT_MAX;
                    propagate  = 1'b1;
                end else begin
                    next_value = value - 4'd1;
                end
            end
        end
    end

endmodule : bcd_digit

// File: rtl/bcd_multi_counter.sv
// -----------------------------------------------------------------------------
// bcd_multi_counter
// Up/down cascaded BCD counter with parallel load, wrap or saturate at the
// count limits, and a one-cycle carry/borrow-out pulse. The whole carry chain
// settles combinationally, so every count step takes exactly one clock.
//
// Parameters:
//   DIGITS : number of cascaded BCD digits (1..8)
//   WRAP   : 1 = modulo 10^DIGITS wrap, 0 = saturate at all-9s / all-0s
// Ports:
//   CLK      : clock, all state changes on the rising edge
//   RST      : synchronous active-high reset (Q, CO, LOAD_ERR cleared)
//   ENABLE   : count enable
//   LOAD     : parallel load request (takes priority over ENABLE)
//   UP       : direction for this cycle, 1 = up, 0 = down
//   D        : load value, digit 0 in D[3:0]
//   Q        : registered count, digit 0 in Q[3:0]
//   CO       : registered carry/borrow-out pulse (wrap or limit attempt)
//   ZERO     : combinational flag, Q is all zero
//   LOAD_ERR : registered flag, previous cycle loaded an out-of-range digit
//
// Configuration macro: BCDCNT_LOADCHK_EN
//   defined   : D digits above 9 are clamped to 9 on load and LOAD_ERR pulses
//   undefined : D is loaded unmodified and LOAD_ERR is tied low
// -----------------------------------------------------------------------------
module bcd_multi_counter
    import bcdcnt_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int WRAP   = 1
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        ENABLE,
    input  logic                        LOAD,
    input  logic                        UP,
    input  logic [DIGIT_W*DIGITS-1:0]   D,
    output logic [DIGIT_W*DIGITS-1:0]   Q,
    output logic                        CO,
    output logic                        ZERO,
    output logic                        LOAD_ERR
);

    localparam int W = DIGIT_W * DIGITS;

    // chain[k] high means digit k steps this cycle; chain[DIGITS] high means
    // the whole counter rolled over (wrap or limit attempt).
    logic [DIGITS:0] chain;
    logic [W-1:0]    q_next;
    logic [W-1:0]    load_value;
    logic [W-1:0]    limit;

    assign chain[0] = 1'b1;

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        bcd_digit u_digit (
            .up         (UP),
            .advance    (chain[k]),
            .value      (Q[k*DIGIT_W +: DIGIT_W]),
            .next_value (q_next[k*DIGIT_W +: DIGIT_W]),
            .propagate  (chain[k+1])
        );
    end

    // Saturation target: the limit the count just tried to pass.
    always_comb begin
        limit = '0;
        if (UP) begin
            limit = {DIGITS{DIGIT_MAX}};
        end
    end

`ifdef BCDCNT_LOADCHK_EN
    logic load_bad;

    always_comb begin
        load_value = '0;
        load_bad   = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            load_value[k*DIGIT_W +: DIGIT_W] = clamp_digit(D[k*DIGIT_W +: DIGIT_W]);
            if (D[k*DIGIT_W +: DIGIT_W] > DIGIT_MAX) begin
                load_bad = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            LOAD_ERR <= 1'b0;
        end else begin
            LOAD_ERR <= LOAD && load_bad;
        end
    end
`else
    assign load_value = D;
    assign LOAD_ERR   = 1'b0;
`endif

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            Q  <= '0;
            CO <= 1'b0;
        end else if (LOAD) begin
            Q  <= load_value;
            CO <= 1'b0;
        end else if (ENABLE) begin
            CO <= chain[DIGITS];
            if (chain[DIGITS] && (WRAP == 0)) begin
                Q <= limit;
            end else begin
                Q <= q_next;
            end
        end else begin
            CO <= 1'b0;
        end
    end

    assign ZERO = (Q == '0);

endmodule : bcd_multi_counter

// File: tb/tb_bcd_multi_counter.sv
// -----------------------------------------------------------------------------
// tb_bcd_multi_counter
// Drives a wrapping and a saturating 4-digit counter from the same inputs and
// compares both against an arithmetic model every cycle, plus hand-computed
// expectations for the key scenarios. Honours BCDCNT_LOADCHK_EN.
// -----------------------------------------------------------------------------
module tb_bcd_multi_counter;

    localparam int N   = 4;
    localparam int W   = 4 * N;
    localparam int LIM = 9999;

`ifdef BCDCNT_LOADCHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic         CLK;
    logic         RST;
    logic         ENABLE;
    logic         LOAD;
    logic         UP;
    logic [W-1:0] D;

    logic [W-1:0] q_w, q_s;
    logic         co_w, co_s, zero_w, zero_s, err_w, err_s;

    int checks = 0;
    int errors = 0;

    bcd_multi_counter #(.DIGITS(N), .WRAP(1)) dut (
        .CLK(CLK), .RST(RST), .ENABLE(ENABLE), .LOAD(LOAD), .UP(UP), .D(D),
        .Q(q_w), .CO(co_w), .ZERO(zero_w), .LOAD_ERR(err_w)
    );

    bcd_multi_counter #(.DIGITS(N), .WRAP(0)) dut_sat (
        .CLK(CLK), .RST(RST), .ENABLE(ENABLE), .LOAD(LOAD), .UP(UP), .D(D),
        .Q(q_s), .CO(co_s), .ZERO(zero_s), .LOAD_ERR(err_s)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        r = '0;
        for (int k = 0; k < N; k++) begin
            r[k*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic int from_bcd(input logic [W-1:0] q);
        int v;
        v = 0;
        for (int k = N - 1; k >= 0; k--) v = v * 10 + int'(q[k*4 +: 4]);
        return v;
    endfunction

    function automatic bit all_valid(input logic [W-1:0] q);
        for (int k = 0; k < N; k++) if (q[k*4 +: 4] > 4'd9) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_step(input logic [W-1:0] q, input bit up, input bit wrap,
                              output logic [W-1:0] nq, output bit co);
        int  v;
        bit  go;
        logic [3:0] dg;
        if (all_valid(q)) begin
            v  = from_bcd(q);
            co = up ? (v == LIM) : (v == 0);
            if (co) v = wrap ? (up ? 0 : LIM) : v;
            else    v = up ? v + 1 : v - 1;
            nq = to_bcd(v);
        end else begin
            // Digit-level rule for out-of-range contents.
            nq = q;
            go = 1'b1;
            for (int k = 0; k < N; k++) begin
                if (go) begin
                    dg = q[k*4 +: 4];
                    if (up) begin
                        if (dg >= 4'd9) nq[k*4 +: 4] = 4'd0;
                        else begin nq[k*4 +: 4] = dg + 4'd1; go = 1'b0; end
                    end else begin
                        if (dg == 4'd0) nq[k*4 +: 4] = 4'd9;
                        else begin nq[k*4 +: 4] = dg - 4'd1; go = 1'b0; end
                    end
                end
            end
            co = go;
            if (go && !wrap) nq = up ? to_bcd(LIM) : '0;
        end
    endtask

    logic [W-1:0] m_q_w, m_q_s;
    bit           m_co_w, m_co_s, m_err;
    bit           model_live = 1'b0;

    always @(posedge CLK) begin
        logic [W-1:0] lq, nq;
        bit           bad, c;
        if (RST) begin
            m_q_w = '0; m_q_s = '0; m_co_w = 0; m_co_s = 0; m_err = 0;
            model_live = 1'b1;
        end else if (LOAD) begin
            lq  = D;
            bad = 1'b0;
            for (int k = 0; k < N; k++) begin
                if (CHK && D[k*4 +: 4] > 4'd9) begin
                    lq[k*4 +: 4] = 4'd9;
                    bad = 1'b1;
                end
            end
            m_q_w = lq; m_q_s = lq; m_co_w = 0; m_co_s = 0; m_err = bad;
        end else if (ENABLE) begin
            model_step(m_q_w, UP, 1'b1, nq, c); m_q_w = nq; m_co_w = c;
            model_step(m_q_s, UP, 1'b0, nq, c); m_q_s = nq; m_co_s = c;
            m_err = 0;
        end else begin
            m_co_w = 0; m_co_s = 0; m_err = 0;
        end
    end

    always @(negedge CLK) begin
        if (model_live) begin
            check("model_q_wrap",    q_w,    m_q_w);
            check("model_co_wrap",   co_w,   m_co_w);
            check("model_zero_wrap", zero_w, m_q_w == '0);
            check("model_err_wrap",  err_w,  m_err);
            check("model_q_sat",     q_s,    m_q_s);
            check("model_co_sat",    co_s,   m_co_s);
            check("model_zero_sat",  zero_s, m_q_s == '0);
            check("model_err_sat",   err_s,  m_err);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    logic [W-1:0] exp_q_s [3] = '{16'h9999, 16'h9999, 16'h9999};
    logic         exp_co_s[3] = '{1'b0, 1'b1, 1'b1};
    logic [W-1:0] exp_q_w [3] = '{16'h9999, 16'h0000, 16'h0001};
    logic         exp_co_w[3] = '{1'b0, 1'b1, 1'b0};
    logic         tgl_up  [3] = '{1'b1, 1'b0, 1'b1};
    logic [W-1:0] tgl_q   [3] = '{16'h0991, 16'h0990, 16'h0991};

    initial begin
        int co_hits;

        // Reset overrides LOAD and ENABLE in the same cycle.
        RST = 1; LOAD = 1; ENABLE = 1; UP = 1; D = 16'h1234;
        tick();
        check("rst_q", q_w, 16'h0000);
        check("rst_co", co_w, 1'b0);
        check("rst_err", err_w, 1'b0);
        check("rst_zero", zero_w, 1'b1);
        check("rst_q_sat", q_s, 16'h0000);

        RST = 0; LOAD = 1; ENABLE = 0; D = 16'h1234;
        tick();
        check("load_1234", q_w, 16'h1234);
        check("load_zero_flag", zero_w, 1'b0);

        // Full up-count sweep 0000..9999..0000.
        RST = 1; LOAD = 0;
        tick();
        RST = 0; ENABLE = 1; UP = 1;
        co_hits = 0;
        for (int i = 1; i <= 10000; i++) begin
            tick();
            if (co_w) co_hits++;
            if (i == 1) check("sweep_first", q_w, 16'h0001);
            if (i == 9999) begin
                check("sweep_9999", q_w, 16'h9999);
                check("sweep_9999_co", co_w, 1'b0);
            end
            if (i == 10000) begin
                check("sweep_wrap_q", q_w, 16'h0000);
                check("sweep_wrap_co", co_w, 1'b1);
                check("sweep_wrap_zero", zero_w, 1'b1);
                check("sweep_sat_q", q_s, 16'h9999);
                check("sweep_sat_co", co_s, 1'b1);
            end
        end
        check("sweep_co_count", co_hits, 1);

        ENABLE = 0;
        tick();
        check("hold_q", q_w, 16'h0000);
        check("hold_co", co_w, 1'b0);

        // Down-count borrow and wrap.
        LOAD = 1; D = 16'h0100;
        tick();
        LOAD = 0; ENABLE = 1; UP = 0;
        tick();
        check("down_0099", q_w, 16'h0099);
        check("down_0099_co", co_w, 1'b0);
        LOAD = 1; ENABLE = 0; D = 16'h0000;
        tick();
        LOAD = 0; ENABLE = 1; UP = 0;
        tick();
        check("down_wrap_q", q_w, 16'h9999);
        check("down_wrap_co", co_w, 1'b1);
        check("down_sat_q", q_s, 16'h0000);
        check("down_sat_co", co_s, 1'b1);

        // Saturation at the top versus wrap.
        LOAD = 1; ENABLE = 0; D = 16'h9998;
        tick();
        LOAD = 0; ENABLE = 1; UP = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("sat_top_q", q_s, exp_q_s[i]);
            check("sat_top_co", co_s, exp_co_s[i]);
            check("wrap_top_q", q_w, exp_q_w[i]);
            check("wrap_top_co", co_w, exp_co_w[i]);
        end

        // Out-of-range load value.
        LOAD = 1; ENABLE = 0; D = 16'h12F4;
        tick();
        check("bad_load_q", q_w, CHK ? 16'h1294 : 16'h12F4);
        check("bad_load_err", err_w, CHK);
        LOAD = 0;
        tick();
        check("bad_load_err_clear", err_w, 1'b0);

        // Counting through out-of-range digits.
        LOAD = 1; D = 16'h00F9;
        tick();
        LOAD = 0; ENABLE = 1; UP = 1;
        tick();
        check("oor_up_q", q_w, 16'h0100);
        check("oor_up_co", co_w, 1'b0);
        LOAD = 1; ENABLE = 0; D = 16'h00F0;
        tick();
        LOAD = 0; ENABLE = 1; UP = 0;
        tick();
        check("oor_down_q", q_w, CHK ? 16'h0089 : 16'h00E9);
        check("oor_down_co", co_w, 1'b0);

        // Direction toggled every cycle.
        LOAD = 1; ENABLE = 0; D = 16'h0990;
        tick();
        LOAD = 0; ENABLE = 1;
        for (int i = 0; i < 3; i++) begin
            UP = tgl_up[i];
            tick();
            check("toggle_q", q_w, tgl_q[i]);
            check("toggle_zero", zero_w, 1'b0);
        end

        // Reset while counting lands on the next edge only.
        UP = 1; RST = 1;
        tick();
        check("midcount_rst_q", q_w, 16'h0000);
        RST = 0;
        tick();
        check("after_rst_q", q_w, 16'h0001);

        ENABLE = 0;
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_bcd_multi_counter
